// File: rtl/div_pkg.sv
// Shared constants and state encoding for the shared-divider controller.
package div_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] ST_OK = 2'b00;
    localparam logic [1:0] ST_DZ = 2'b01;
    localparam logic [1:0] ST_TO = 2'b10;

    localparam logic [DATA_W-1:0] DZ_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] DZ_NEG = 16'h8000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... modulo N.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any
);

    logic [ID_W-1:0] w_shift;
    logic [N-1:0]    w_rot;
    logic [N-1:0]    w_first;

    // Rotate so the highest-priority requester sits at bit 0, pick lowest, rotate back.
    assign w_shift = (last == ID_W'(N - 1)) ? '0 : last + 1'b1;
    assign w_rot   = N'({req, req} >> w_shift);

    genvar gi, gb;
    generate
        for (gi = 0; gi < N; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign w_first[gi] = w_rot[gi];
            end else begin : g_rest
                assign w_first[gi] = w_rot[gi] & ~(|w_rot[gi-1:0]);
            end
        end
    endgenerate

    assign grant = N'(({w_first, w_first} << w_shift) >> N);
    assign any   = |req;

    generate
        for (gb = 0; gb < ID_W; gb++) begin : g_enc
            logic [N-1:0] w_mask;
            for (gi = 0; gi < N; gi++) begin : g_mask
                assign w_mask[gi] = 1'(gi >> gb);
            end
            assign grant_idx[gb] = |(grant & w_mask);
        end
    endgenerate

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one sequential divider among N requesters with round-robin arbitration,
// divide-by-zero short-circuit and a watchdog on divider completion.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int N       = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req_valid,
    output logic [N-1:0]          req_ready,
    input  logic [N*DATA_W-1:0]   req_num,
    input  logic [N*DATA_W-1:0]   req_den,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [DATA_W-1:0]     resp_quotient,
    output logic [1:0]            resp_status,
    output logic                  div_start,
    output logic [DATA_W-1:0]     div_numerator,
    output logic [DATA_W-1:0]     div_denominator,
    input  logic [DATA_W-1:0]     div_quotient,
    input  logic                  div_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [DATA_W-1:0] w_num_arr [N];
    logic [DATA_W-1:0] w_den_arr [N];
    logic [N-1:0]      w_grant;
    logic [ID_W-1:0]   w_gidx;
    logic              w_any;
    logic [DATA_W-1:0] w_num;
    logic [DATA_W-1:0] w_den;

    state_t            r_state;
    logic [ID_W-1:0]   r_last;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_quot;
    logic [1:0]        r_status;
    logic              r_resp_valid;
    logic              r_div_start;
    logic [DATA_W-1:0] r_div_num;
    logic [DATA_W-1:0] r_div_den;
    logic [CNT_W-1:0]  r_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_num_arr[gi] = req_num[gi*DATA_W +: DATA_W];
            assign w_den_arr[gi] = req_den[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .N    (N),
        .ID_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .last      (r_last),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .any       (w_any)
    );

    assign w_num = w_num_arr[w_gidx];
    assign w_den = w_den_arr[w_gidx];

    // Accept strobe is combinational so the transfer completes in the grant cycle.
    assign req_ready = (r_state == S_IDLE && !reset) ? w_grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last       <= ID_W'(N - 1);
            r_id         <= '0;
            r_quot       <= '0;
            r_status     <= ST_OK;
            r_resp_valid <= 1'b0;
            r_div_start  <= 1'b0;
            r_div_num    <= '0;
            r_div_den    <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id <= w_gidx;
                        if (w_den == '0) begin
                            r_quot       <= w_num[DATA_W-1] ? DZ_NEG : DZ_POS;
                            r_status     <= ST_DZ;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_div_num   <= w_num;
                            r_div_den   <= w_den;
                            r_div_start <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_div_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (div_done) begin
                        r_quot       <= div_quotient;
                        r_status     <= ST_OK;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_quot       <= '0;
                        r_status     <= ST_TO;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_last       <= r_id;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign resp_valid      = r_resp_valid;
    assign resp_id         = r_id;
    assign resp_quotient   = r_quot;
    assign resp_status     = r_status;
    assign div_start       = r_div_start;
    assign div_numerator   = r_div_num;
    assign div_denominator = r_div_den;

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
Round-robin scheduler that shares one RestoringDivider16-style sequential divider (start/numerator/denominator in, quotient/done out) among N requesters. It accepts one request at a time over per-requester valid/ready and launches the divider with a one-cycle start pulse. It returns the quotient on a single tagged response channel. Divide-by-zero requests are short-circuited without using the divider, and a watchdog bounds how long the controller waits for done.

Parameters:
N, 4, number of requesters (2..8)
ID_W, 2, width of resp_id, equal to clog2(N)
TIMEOUT, 32, max cycles spent in WAIT before aborting

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  N  per-requester request valid
req_ready  output  N  per-requester accept strobe (one-hot or zero)
req_num  input  N*16  packed signed numerators; requester i in bits [16i+15:16i]
req_den  input  N*16  packed signed denominators; same packing
resp_valid  output  1  response valid
resp_ready  input  1  response consumer ready
resp_id  output  ID_W  index of the requester being answered
resp_quotient  output  16  signed quotient
resp_status  output  2  00 ok, 01 divide-by-zero, 10 timeout
div_start  output  1  one-cycle start pulse to the divider
div_numerator  output  16  operand to the divider, held stable from ISSUE through WAIT
div_denominator  output  16  operand to the divider, held stable from ISSUE through WAIT
div_quotient  input  16  divider result
div_done  input  1  divider one-cycle completion pulse

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all outputs 0.
  - Round-robin pointer last=N-1, so requester 0 has top priority first.
  - The divider shares the same reset.
  - Reset in any state aborts the transaction; no response is produced.
- IDLE:
  - If any req_valid is high, grant g = first asserted index searching last+1, last+2, ... modulo N.
  - Assert req_ready[g] combinationally in the same cycle; the transfer happens that cycle.
  - Latch num, den and id=g.
  - Next state: RESP with status 01 if den==0, otherwise ISSUE.
- Divide-by-zero result: quotient 16'h7FFF if num>=0, 16'h8000 if num<0. div_start is never asserted.
- ISSUE:
  - div_start=1 for exactly one cycle with operands valid; then go to WAIT.
  - Clear the watchdog counter.
- WAIT:
  - div_start=0 and operands held.
  - On div_done=1: capture div_quotient, status 00, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without done: quotient 0, status 10, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - resp_valid=1; resp_id, resp_quotient and resp_status are stable while resp_ready=0.
  - On resp_valid&&resp_ready: last=id, return to IDLE.
  - The earliest new accept is the following cycle, so there is no back-to-back accept in the handshake cycle.
- req_ready is 0 in every state except IDLE.
- At most one outstanding transaction; a requester may deassert req_valid at any time before it is granted.
- Latency for a nonzero-denominator request:
  - accept (cycle 0) -> ISSUE (1) -> divider busy.
  - resp_valid rises the cycle after div_done is sampled.
  - With the 16-iteration divider, about 20 cycles accept-to-response.
- Divide-by-zero latency: resp_valid at cycle 1.
- A stray div_done outside WAIT is ignored.
- Signed semantics are handled by the divider; the controller passes operands unmodified.

Decomposition:
- Package div_pkg:
  - DATA_W=16.
  - Status localparams ST_OK=2'b00, ST_DZ=2'b01, ST_TO=2'b10.
  - State encoding IDLE/ISSUE/WAIT/RESP.
  - Divide-by-zero saturation constants 16'h7FFF and 16'h8000.
- Sub-module rr_arbiter (parameter N): inputs req[N] and last pointer; outputs grant one-hot, grant index and any.
  - Purely combinational; the pointer register stays in div_share_ctrl.

Test Plan:
- Req0 100/7 alone, real divider attached -> req_ready[0] pulses once; div_start one pulse; resp_id=0, quotient 14 (16'h000E), status 00.
- Req2 -100/7 -> quotient 16'hFFF2 (-14), status 00. Req1 -100/-7 -> 16'h000E.
- All four requesters assert 10/2 simultaneously and hold valid, resp_ready=1 -> grants in order 0,1,2,3. Requester 0 then re-requests and is served after 3, with no starvation; four responses of quotient 5.
- Req3 -5/0 -> resp_valid one cycle after accept, quotient 16'h8000, status 01, div_start never high. Req3 5/0 -> quotient 16'h7FFF, status 01.
- resp_ready held low 6 cycles during RESP -> response fields stable; all req_ready stay 0. Raising resp_ready -> IDLE and the next grant goes to the next index after id.
- Stub divider that never asserts done -> after TIMEOUT cycles in WAIT: status 10, quotient 0.
- Reset asserted mid-WAIT -> all outputs 0 immediately. After release, requester 0 wins when all requesters are valid.
